cursor_ctrl: RTL and testbench
==============================

Name: cursor_ctrl

Overview:
Per-frame controller for the on-screen drawing cursor. Captures raw tracker positions, clamps them to the half-resolution canvas (640x360), and commits them to the cursor sprite only at frame boundaries so the sprite never tears mid-frame. Also owns the cursor style settings (color, stroke width, cursor type), which change on button rising edges. Issues a valid/ready stroke request to the framebuffer painter for each committed position while drawing is enabled.

Parameters:
X_MAX, 639, largest legal canvas x (half-res units).
Y_MAX, 359, largest legal canvas y.
NUM_COLORS, 16, color index wraps modulo this value (must be at most 16).
LOST_FRAMES, 8, number of consecutive frames without a position before tracking is declared lost (1..255).

Ports:
clk_in  input  1  pixel clock; all logic is on the rising edge
rst_in  input  1  synchronous, active-high reset
new_frame_in  input  1  single-cycle pulse at start of vertical blanking
pos_valid_in  input  1  tracker position valid strobe
pos_x_in  input  10  raw tracker x (may exceed X_MAX)
pos_y_in  input  9  raw tracker y (may exceed Y_MAX)
btn_color_in  input  1  debounced level; rising edge advances color
btn_width_in  input  1  debounced level; rising edge advances stroke width
btn_type_in  input  1  debounced level; rising edge toggles cursor type
draw_en_in  input  1  level; pen down
draw_ready_in  input  1  painter accepts the stroke request
x_out  output  10  committed cursor x to the sprite
y_out  output  9  committed cursor y to the sprite
cursor_color_out  output  4  color index
stroke_width_out  output  3  stroke width
cursor_type_out  output  1  1 = crosshair, 0 = box
tracking_out  output  1  1 while a position has arrived within the last LOST_FRAMES frames
draw_valid_out  output  1  stroke request valid
draw_x_out  output  10  stroke request x
draw_y_out  output  9  stroke request y

Behaviour:
- Reset values: x_out=320, y_out=180, color=0, width=0, type=1, tracking_out=0, draw_valid_out=0, draw_x/draw_y=0, pending flag=0, lost counter=LOST_FRAMES. Button edge-history registers are cleared to 0, so a button held high through reset registers one edge on the first cycle after reset.
- Capture: on any cycle with pos_valid_in=1, store the clamped values in pend_x/pend_y and set pend. Clamping is min(pos_x_in, X_MAX) and min(pos_y_in, Y_MAX). If several positions arrive in one frame, the last one wins.
- Commit at new_frame_in (outputs change on the next cycle):
  - If pend=1 (including a pos_valid_in in the same cycle, which takes priority as the value): x_out/y_out take the pending or incoming value, pend clears, and the lost counter clears to 0.
  - Otherwise the lost counter increments, saturating at LOST_FRAMES.
  - tracking_out = (lost counter < LOST_FRAMES), registered.
- Stroke FSM, states IDLE and REQ:
  - IDLE -> REQ on the cycle after a commit with pend=1, provided draw_en_in=1 and tracking is true. draw_valid_out rises together with the loaded draw_x/draw_y.
  - REQ: draw_valid_out and draw_x/draw_y hold stable until the cycle in which draw_ready_in=1. After that handshake cycle, return to IDLE with draw_valid_out=0.
  - A commit that happens while in REQ still updates x_out/y_out, but its stroke is dropped and the outstanding request is not altered.
  - draw_en_in falling during REQ does not withdraw the request.
- Settings: a rising edge is the current sample = 1 while the previous sample = 0. The output updates one cycle after the edge is sampled.
  - color = (color+1) mod NUM_COLORS.
  - width increments and wraps 7 -> 0.
  - type toggles.
  - Simultaneous edges on different buttons are all applied in the same cycle.
- Reset asserted mid-request drops the request immediately: draw_valid_out=0 on the next cycle.

Optional Feature:
CURSOR_SMOOTH_EN.
- Defined: the commit writes the rounded average of old and new position, x_out=(x_out+pend_x+1)>>1, computed in 11 bits; y_out likewise in 10 bits. The stroke request uses the smoothed value. The first commit after tracking was lost (lost counter = LOST_FRAMES) loads the raw value without averaging.
- Undefined: the commit writes the pending value directly.

Test Plan:
1. Reset, then pos_valid with (700,400), then new_frame -> next cycle x_out=639, y_out=359, tracking_out=1.
2. Positions (10,20) then (30,40) within one frame, then new_frame -> x_out=30, y_out=40. Eight following frames with no position -> tracking_out=0 after the 8th new_frame.
3. draw_en=1, commit (100,50), draw_ready held 0 for 5 cycles -> draw_valid stays 1 with (100,50). A second commit (110,60) during the wait leaves the request unchanged. draw_ready=1 -> draw_valid=0 next cycle.
4. Three btn_color rising edges from 15 with NUM_COLORS=16 -> 0,1,2. btn_width and btn_type rising in the same cycle -> width+1 and type toggled together. btn_color held high 100 cycles -> exactly one increment.
5. Reset asserted while in REQ -> draw_valid=0 and all outputs at reset values next cycle.
6. CURSOR_SMOOTH_EN: with x_out=100, commit 201 -> x_out=151. With tracking lost, commit 500 -> x_out=500.

Source files
------------

// File: rtl/cursor_ctrl_if.sv
// Stroke request channel from cursor_ctrl to the framebuffer painter.
// Valid/ready handshake: the request is held stable until ready is seen.
interface cursor_ctrl_if;
  logic       draw_valid_out;
  logic [9:0] draw_x_out;
  logic [8:0] draw_y_out;
  logic       draw_ready_in;

  modport master (
    output draw_valid_out,
    output draw_x_out,
    output draw_y_out,
    input  draw_ready_in
  );

  modport slave (
    input  draw_valid_out,
    input  draw_x_out,
    input  draw_y_out,
    output draw_ready_in
  );
endinterface

// File: rtl/cursor_ctrl.sv
// Per-frame cursor controller: clamps tracker positions, commits them at frame boundaries,
// owns cursor style settings and issues stroke requests. Optional macro: CURSOR_SMOOTH_EN.
module cursor_ctrl #(
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 359,
  parameter int unsigned NUM_COLORS  = 16,
  parameter int unsigned LOST_FRAMES = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                new_frame_in,
  input  logic                pos_valid_in,
  input  logic [9:0]          pos_x_in,
  input  logic [8:0]          pos_y_in,
  input  logic                btn_color_in,
  input  logic                btn_width_in,
  input  logic                btn_type_in,
  input  logic                draw_en_in,
  output logic [9:0]          x_out,
  output logic [8:0]          y_out,
  output logic [3:0]          cursor_color_out,
  output logic [2:0]          stroke_width_out,
  output logic                cursor_type_out,
  output logic                tracking_out,
  cursor_ctrl_if.master       draw
);

  localparam logic [9:0] XMax      = 10'(X_MAX);
  localparam logic [8:0] YMax      = 9'(Y_MAX);
  localparam logic [7:0] LostMax   = 8'(LOST_FRAMES);
  localparam logic [3:0] ColorLast = 4'(NUM_COLORS - 1);
  localparam logic [9:0] XHome     = 10'd320;
  localparam logic [8:0] YHome     = 9'd180;

  typedef enum logic {StIdle, StReq} stroke_st_e;

  stroke_st_e st_q, st_d;

  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [9:0] pend_x_q, pend_x_d;
  logic [8:0] pend_y_q, pend_y_d;
  logic       pend_q, pend_d;
  logic [7:0] lost_q, lost_d;
  logic       tracking_q, tracking_d;
  logic [9:0] dx_q, dx_d;
  logic [8:0] dy_q, dy_d;

  logic [3:0] color_q, color_d;
  logic [2:0] width_q, width_d;
  logic       type_q, type_d;
  logic       btn_color_q, btn_width_q, btn_type_q;
  logic       color_edge, width_edge, type_edge;

  logic [9:0] clamp_x;
  logic [8:0] clamp_y;
  logic [9:0] src_x, new_x;
  logic [8:0] src_y, new_y;
  logic       commit;

  assign clamp_x = (pos_x_in > XMax) ? XMax : pos_x_in;
  assign clamp_y = (pos_y_in > YMax) ? YMax : pos_y_in;

  // A same-cycle position wins over the stored pending one at the frame boundary.
  assign commit = new_frame_in & (pend_q | pos_valid_in);
  assign src_x  = pos_valid_in ? clamp_x : pend_x_q;
  assign src_y  = pos_valid_in ? clamp_y : pend_y_q;

`ifdef CURSOR_SMOOTH_EN
  logic [10:0] sum_x;
  logic [9:0]  sum_y;

  assign sum_x = {1'b0, x_q} + {1'b0, src_x} + 11'd1;
  assign sum_y = {1'b0, y_q} + {1'b0, src_y} + 10'd1;
  // After tracking loss the old position is stale, so jump straight to the new one.
  assign new_x = (lost_q == LostMax) ? src_x : sum_x[10:1];
  assign new_y = (lost_q == LostMax) ? src_y : sum_y[9:1];
`else
  assign new_x = src_x;
  assign new_y = src_y;
`endif

  always_comb begin
    pend_d   = pend_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    x_d      = x_q;
    y_d      = y_q;
    lost_d   = lost_q;

    if (pos_valid_in) begin
      pend_d   = 1'b1;
      pend_x_d = clamp_x;
      pend_y_d = clamp_y;
    end

    if (new_frame_in) begin
      pend_d = 1'b0;
      if (commit) begin
        x_d    = new_x;
        y_d    = new_y;
        lost_d = 8'd0;
      end else if (lost_q < LostMax) begin
        lost_d = lost_q + 8'd1;
      end
    end

    tracking_d = (lost_d < LostMax);
  end

  always_comb begin
    st_d = st_q;
    dx_d = dx_q;
    dy_d = dy_q;
    unique case (st_q)
      StIdle: begin
        if (commit && draw_en_in && tracking_d) begin
          st_d = StReq;
          dx_d = new_x;
          dy_d = new_y;
        end
      end
      StReq: begin
        // Commits during an outstanding request are not queued; only ready ends it.
        if (draw.draw_ready_in) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  assign color_edge = btn_color_in & ~btn_color_q;
  assign width_edge = btn_width_in & ~btn_width_q;
  assign type_edge  = btn_type_in & ~btn_type_q;

  always_comb begin
    color_d = color_q;
    width_d = width_q;
    type_d  = type_q;
    if (color_edge) begin
      color_d = (color_q >= ColorLast) ? 4'd0 : color_q + 4'd1;
    end
    if (width_edge) begin
      width_d = width_q + 3'd1;
    end
    if (type_edge) begin
      type_d = ~type_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q        <= StIdle;
      x_q         <= XHome;
      y_q         <= YHome;
      pend_q      <= 1'b0;
      pend_x_q    <= 10'd0;
      pend_y_q    <= 9'd0;
      lost_q      <= LostMax;
      tracking_q  <= 1'b0;
      dx_q        <= 10'd0;
      dy_q        <= 9'd0;
      color_q     <= 4'd0;
      width_q     <= 3'd0;
      type_q      <= 1'b1;
      btn_color_q <= 1'b0;
      btn_width_q <= 1'b0;
      btn_type_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pend_q      <= pend_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      lost_q      <= lost_d;
      tracking_q  <= tracking_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      color_q     <= color_d;
      width_q     <= width_d;
      type_q      <= type_d;
      btn_color_q <= btn_color_in;
      btn_width_q <= btn_width_in;
      btn_type_q  <= btn_type_in;
    end
  end

  assign x_out            = x_q;
  assign y_out            = y_q;
  assign cursor_color_out = color_q;
  assign stroke_width_out = width_q;
  assign cursor_type_out  = type_q;
  assign tracking_out     = tracking_q;

  assign draw.draw_valid_out = (st_q == StReq);
  assign draw.draw_x_out     = dx_q;
  assign draw.draw_y_out     = dy_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: capture/clamp/commit, tracking loss, stroke handshake,
// button settings and reset-during-request. Smoothing expectations follow CURSOR_SMOOTH_EN.
module tb_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_frame, pos_valid, btn_color, btn_width, btn_type, draw_en;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic [9:0] x_o;
  logic [8:0] y_o;
  logic [3:0] color_o;
  logic [2:0] width_o;
  logic       type_o, tracking_o;

  int checks = 0;
  int errors = 0;

  // Expected committed position and frames-since-position, kept by the bench.
  int m_x, m_y, m_lost;

  always #5 clk = ~clk;

  cursor_ctrl_if dif ();

  cursor_ctrl dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .new_frame_in     (new_frame),
    .pos_valid_in     (pos_valid),
    .pos_x_in         (pos_x),
    .pos_y_in         (pos_y),
    .btn_color_in     (btn_color),
    .btn_width_in     (btn_width),
    .btn_type_in      (btn_type),
    .draw_en_in       (draw_en),
    .x_out            (x_o),
    .y_out            (y_o),
    .cursor_color_out (color_o),
    .stroke_width_out (width_o),
    .cursor_type_out  (type_o),
    .tracking_out     (tracking_o),
    .draw             (dif)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_x"}, 32'(x_o), 32'd320);
    check_val({tag, "_y"}, 32'(y_o), 32'd180);
    check_val({tag, "_color"}, 32'(color_o), 32'd0);
    check_val({tag, "_width"}, 32'(width_o), 32'd0);
    check_val({tag, "_type"}, 32'(type_o), 32'd1);
    check_val({tag, "_tracking"}, 32'(tracking_o), 32'd0);
    check_val({tag, "_valid"}, 32'(dif.draw_valid_out), 32'd0);
    check_val({tag, "_dx"}, 32'(dif.draw_x_out), 32'd0);
    check_val({tag, "_dy"}, 32'(dif.draw_y_out), 32'd0);
  endtask

  // Position in one cycle, new_frame in the next; model tracks clamp and smoothing.
  task automatic frame_commit(input int x, input int y);
    int cx, cy;
    cx = (x > 639) ? 639 : x;
    cy = (y > 359) ? 359 : y;
    pos_valid = 1'b1;
    pos_x     = 10'(x);
    pos_y     = 9'(y);
    step();
    pos_valid = 1'b0;
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
`ifdef CURSOR_SMOOTH_EN
    if (m_lost < 8) begin
      cx = (m_x + cx + 1) / 2;
      cy = (m_y + cy + 1) / 2;
    end
`endif
    m_x    = cx;
    m_y    = cy;
    m_lost = 0;
  endtask

  task automatic empty_frame();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    step();
    if (m_lost < 8) m_lost++;
  endtask

  task automatic press_color();
    btn_color = 1'b1;
    step();
    btn_color = 1'b0;
    step();
  endtask

  task automatic press_width();
    btn_width = 1'b1;
    step();
    btn_width = 1'b0;
    step();
  endtask

  initial begin
    int exp_dx, exp_dy;
    rst = 1'b1; new_frame = 1'b0; pos_valid = 1'b0; pos_x = '0; pos_y = '0;
    btn_color = 1'b0; btn_width = 1'b0; btn_type = 1'b0; draw_en = 1'b0;
    dif.draw_ready_in = 1'b0;
    m_x = 320; m_y = 180; m_lost = 8;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();

    // Clamp to the canvas corner, pen up so no request.
    frame_commit(700, 400);
    check_val("clamp_x", 32'(x_o), 32'd639);
    check_val("clamp_y", 32'(y_o), 32'd359);
    check_val("clamp_tracking", 32'(tracking_o), 32'd1);
    check_val("pen_up_no_req", 32'(dif.draw_valid_out), 32'd0);

    // Last position in a frame wins; nothing commits before new_frame.
    pos_valid = 1'b1; pos_x = 10'd10; pos_y = 9'd20;
    step();
    pos_valid = 1'b0;
    check_val("no_commit_before_frame", 32'(x_o), 32'd639);
    frame_commit(30, 40);
    check_val("last_wins_x", 32'(x_o), 32'(m_x));
    check_val("last_wins_y", 32'(y_o), 32'(m_y));
    for (int i = 0; i < 7; i++) empty_frame();
    check_val("tracking_after_7", 32'(tracking_o), 32'd1);
    empty_frame();
    check_val("tracking_after_8", 32'(tracking_o), 32'd0);
    check_val("hold_x_when_lost", 32'(x_o), 32'(m_x));

    // Stroke handshake with a stalled painter.
    draw_en = 1'b1;
    frame_commit(100, 50);
    check_val("commit_raw_after_lost", 32'(x_o), 32'd100);
    check_val("req_valid", 32'(dif.draw_valid_out), 32'd1);
    check_val("req_x", 32'(dif.draw_x_out), 32'd100);
    check_val("req_y", 32'(dif.draw_y_out), 32'd50);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("req_hold_valid", 32'(dif.draw_valid_out), 32'd1);
      check_val("req_hold_x", 32'(dif.draw_x_out), 32'd100);
    end
    frame_commit(110, 60);
    check_val("commit_in_req_x", 32'(x_o), 32'(m_x));
    check_val("commit_in_req_y", 32'(y_o), 32'(m_y));
    check_val("req_unchanged_x", 32'(dif.draw_x_out), 32'd100);
    check_val("req_unchanged_y", 32'(dif.draw_y_out), 32'd50);
    check_val("req_unchanged_valid", 32'(dif.draw_valid_out), 32'd1);
    draw_en = 1'b0;
    step();
    check_val("pen_lift_keeps_req", 32'(dif.draw_valid_out), 32'd1);
    dif.draw_ready_in = 1'b1;
    step();
    dif.draw_ready_in = 1'b0;
    check_val("req_done", 32'(dif.draw_valid_out), 32'd0);
    step();
    check_val("req_stays_idle", 32'(dif.draw_valid_out), 32'd0);

    // Color wraps modulo 16.
    for (int i = 0; i < 15; i++) press_color();
    check_val("color_15", 32'(color_o), 32'd15);
    press_color();
    check_val("color_wrap_0", 32'(color_o), 32'd0);
    press_color();
    check_val("color_1", 32'(color_o), 32'd1);
    press_color();
    check_val("color_2", 32'(color_o), 32'd2);

    // Simultaneous width and type edges.
    btn_width = 1'b1; btn_type = 1'b1;
    step();
    btn_width = 1'b0; btn_type = 1'b0;
    step();
    check_val("width_simul", 32'(width_o), 32'd1);
    check_val("type_simul", 32'(type_o), 32'd0);
    check_val("color_untouched", 32'(color_o), 32'd2);

    // Held button counts once.
    btn_color = 1'b1;
    for (int i = 0; i < 100; i++) step();
    btn_color = 1'b0;
    step();
    check_val("held_color_once", 32'(color_o), 32'd3);

    for (int i = 0; i < 6; i++) press_width();
    check_val("width_7", 32'(width_o), 32'd7);
    press_width();
    check_val("width_wrap_0", 32'(width_o), 32'd0);

    // Reset during an outstanding request, button held high through reset.
    draw_en = 1'b1;
    frame_commit(200, 100);
    exp_dx = m_x;
    exp_dy = m_y;
    check_val("req2_valid", 32'(dif.draw_valid_out), 32'd1);
    check_val("req2_x", 32'(dif.draw_x_out), 32'(exp_dx));
    check_val("req2_y", 32'(dif.draw_y_out), 32'(exp_dy));
    draw_en = 1'b0;
    rst = 1'b1; btn_color = 1'b1;
    step();
    check_reset_state("rst_in_req");
    rst = 1'b0;
    m_x = 320; m_y = 180; m_lost = 8;
    step();
    btn_color = 1'b0;
    step();
    check_val("edge_after_reset", 32'(color_o), 32'd1);

    // Smoothing (raw pass-through when the macro is off).
    frame_commit(100, 100);
    check_val("sm_first_raw", 32'(x_o), 32'd100);
    frame_commit(201, 100);
`ifdef CURSOR_SMOOTH_EN
    check_val("sm_avg_x", 32'(x_o), 32'd151);
`else
    check_val("sm_avg_x", 32'(x_o), 32'd201);
`endif
    check_val("sm_model_y", 32'(y_o), 32'(m_y));
    for (int i = 0; i < 8; i++) empty_frame();
    frame_commit(500, 10);
    check_val("sm_lost_raw_x", 32'(x_o), 32'd500);
    check_val("sm_lost_raw_y", 32'(y_o), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
